// File: rtl/forest_vote_pkg.sv
// forest_vote_pkg: shared state encoding, derived widths and parameter legality for the streaming voter
package forest_vote_pkg;
  typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_e;
  localparam int TIE_LOWEST = 0;
  localparam int TIE_FIXED = 1;
  function automatic int cnt_w(int trees);
    return $clog2(trees + 1);
  endfunction
  function automatic int beat_w(int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
  function automatic bit params_ok(int nt, int nc, int cw, int tpb, int tm, int tc);
    return tpb >= 1 && nt % tpb == 0 && nc >= 2 && (1 << cw) >= nc &&
           (tm == TIE_LOWEST || tm == TIE_FIXED) && tc >= 0 && tc < nc;
  endfunction
endpackage

// File: rtl/majority_vote_stream_if.sv
// majority_vote_stream_if: vote input stream and result output stream of the voter
interface majority_vote_stream_if #(
  parameter int TREES_PER_BEAT = 2,
  parameter int CLASS_W = 2,
  parameter int CNT_W = 3
);
  logic in_valid;
  logic in_ready;
  logic [TREES_PER_BEAT*CLASS_W-1:0] in_votes;
  logic out_valid;
  logic out_ready;
  logic [CLASS_W-1:0] out_class;
  logic [CNT_W-1:0] out_count;
  logic out_tie;
  logic out_err;
  modport master(output in_valid, in_votes, out_ready,
                 input in_ready, out_valid, out_class, out_count, out_tie, out_err);
  modport slave(input in_valid, in_votes, out_ready,
                output in_ready, out_valid, out_class, out_count, out_tie, out_err);
endinterface

// File: rtl/majority_vote_counter_bank.sv
// majority_vote_counter_bank: per-class vote counters with multi-lane increment and invalid-vote detect
module majority_vote_counter_bank #(
  parameter int NUM_CLASSES = 4,
  parameter int CLASS_W = 2,
  parameter int TREES_PER_BEAT = 2,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic [TREES_PER_BEAT*CLASS_W-1:0] votes_i,
  output logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_o,
  output logic bad_o
);
  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    bad_o = 1'b0;
    for (int l = 0; l < TREES_PER_BEAT; l++)
      bad_o = bad_o | (int'(votes_i[l*CLASS_W +: CLASS_W]) >= NUM_CLASSES);
    for (int c = 0; c < NUM_CLASSES; c++)
      for (int l = 0; l < TREES_PER_BEAT; l++)
        if (en_i && votes_i[l*CLASS_W +: CLASS_W] == CLASS_W'(c)) cnt_d[c] = cnt_d[c] + 1'b1;
    if (clr_i) cnt_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/majority_vote_stream.sv
// majority_vote_stream: accumulates NUM_TREES class votes, scans for the argmax one class per cycle, then
// holds the result on a valid/ready output until consumed
module majority_vote_stream
  import forest_vote_pkg::*;
#(
  parameter int NUM_TREES = 6,
  parameter int NUM_CLASSES = 4,
  parameter int CLASS_W = 2,
  parameter int TREES_PER_BEAT = 2,
  parameter int TIE_MODE = 0,
  parameter int TIE_CLASS = 0
) (
  input logic clk,
  input logic rst_n,
  majority_vote_stream_if.slave bus
);
  localparam int CNT_W = cnt_w(NUM_TREES);
  localparam int NB = NUM_TREES / TREES_PER_BEAT;
  localparam int BEAT_W = beat_w(NB);
  localparam int IDX_W = $clog2(NUM_CLASSES + 1);
  if (!params_ok(NUM_TREES, NUM_CLASSES, CLASS_W, TREES_PER_BEAT, TIE_MODE, TIE_CLASS)) begin : g_bad_params
    $error("majority_vote_stream: illegal parameter combination");
  end
  state_e state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] best_q, best_d, cur, cnt_q, cnt_d;
  logic [CLASS_W-1:0] bidx_q, bidx_d, cls_q, cls_d;
  logic err_q, err_d, tie_q, tie_d, otie_q, otie_d, oerr_q, oerr_d;
  logic acc, clr, bad;
  logic [NUM_CLASSES-1:0][CNT_W-1:0] counts;
  assign acc = bus.in_valid && state_q == ACCUM;
  assign clr = bus.out_ready && state_q == OUT;
  majority_vote_counter_bank #(
    .NUM_CLASSES(NUM_CLASSES), .CLASS_W(CLASS_W), .TREES_PER_BEAT(TREES_PER_BEAT), .CNT_W(CNT_W)
  ) u_bank (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(acc), .votes_i(bus.in_votes), .cnt_o(counts), .bad_o(bad)
  );
  // idx_q runs one past the last class; that extra step registers the result
  always_comb begin
    cur = '0;
    for (int c = 0; c < NUM_CLASSES; c++) if (idx_q == IDX_W'(c)) cur = counts[c];
  end
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    idx_d = idx_q;
    err_d = err_q;
    best_d = best_q;
    bidx_d = bidx_q;
    tie_d = tie_q;
    cls_d = cls_q;
    cnt_d = cnt_q;
    otie_d = otie_q;
    oerr_d = oerr_q;
    unique case (state_q)
      ACCUM: if (acc) begin
        err_d = err_q | bad;
        beat_d = beat_q == BEAT_W'(NB - 1) ? '0 : beat_q + 1'b1;
        state_d = beat_q == BEAT_W'(NB - 1) ? SCAN : ACCUM;
        idx_d = '0;
      end
      SCAN: if (idx_q == IDX_W'(NUM_CLASSES)) begin
        cls_d = (TIE_MODE == TIE_FIXED && tie_q) ? CLASS_W'(TIE_CLASS) : bidx_q;
        cnt_d = best_q;
        otie_d = tie_q;
        oerr_d = err_q;
        state_d = OUT;
      end else begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '0) begin
          best_d = cur;
          bidx_d = '0;
          tie_d = 1'b0;
        end else if (cur > best_q) begin
          best_d = cur;
          bidx_d = CLASS_W'(idx_q);
          tie_d = 1'b0;
        end else if (cur == best_q) tie_d = 1'b1;
      end
      OUT: if (clr) begin
        err_d = 1'b0;
        beat_d = '0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ACCUM;
      beat_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      best_q <= '0;
      bidx_q <= '0;
      tie_q <= 1'b0;
      cls_q <= '0;
      cnt_q <= '0;
      otie_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      idx_q <= idx_d;
      err_q <= err_d;
      best_q <= best_d;
      bidx_q <= bidx_d;
      tie_q <= tie_d;
      cls_q <= cls_d;
      cnt_q <= cnt_d;
      otie_q <= otie_d;
      oerr_q <= oerr_d;
    end
  assign bus.in_ready = state_q == ACCUM;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_class = cls_q;
  assign bus.out_count = cnt_q;
  assign bus.out_tie = otie_q;
  assign bus.out_err = oerr_q;
endmodule

// File: doc/majority_vote_stream.md
Name: majority_vote_stream

Overview:
- Parametrised, sequential successor to the fixed 6-tree/4-class combinational voter.
- Accepts per-tree class votes from the forest as a valid/ready stream, TREES_PER_BEAT votes per beat, and accumulates per-class counts over NUM_TREES votes.
- Runs a one-class-per-cycle argmax scan, then presents winning class, vote count, tie flag and error flag on a valid/ready output.
- Sits between the tree-evaluation array and the IDS alert/result logic.

Parameters:
- NUM_TREES, 6, votes per classification; must be a multiple of TREES_PER_BEAT.
- NUM_CLASSES, 4, number of legal classes; must be at least 2.
- CLASS_W, 2, vote/class field width; 2**CLASS_W must be at least NUM_CLASSES.
- TREES_PER_BEAT, 2, votes accepted per input handshake; must be at least 1.
- TIE_MODE, 0, tie policy: 0 = lowest tied index wins; 1 = output TIE_CLASS on a tie.
- TIE_CLASS, 0, class reported on a tie when TIE_MODE=1.

Ports:
- clk  in  1  clock; all state is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  vote beat valid.
- in_ready  out  1  vote beat accepted when in_valid && in_ready.
- in_votes  in  TREES_PER_BEAT*CLASS_W  lane i occupies bits [i*CLASS_W +: CLASS_W].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_class  out  CLASS_W  winning class.
- out_count  out  CNT_W  vote count of the winning class; CNT_W = clog2(NUM_TREES+1).
- out_tie  out  1  two or more classes shared the maximum count.
- out_err  out  1  at least one vote in the frame was >= NUM_CLASSES.

Behaviour:
- Reset: state ACCUM, all class counters 0, beat counter 0, err latch 0, scan index 0. out_valid, out_class, out_count, out_tie and out_err are all 0. in_ready is 1 once rst_n deasserts.
- Reset applies immediately, at any time; a partial frame is discarded.
- States: ACCUM -> SCAN -> OUT -> ACCUM.
- ACCUM:
  - in_ready=1.
  - On each accepted beat, every lane with vote v < NUM_CLASSES increments count[v]. Multiple lanes with the same v add together in the same cycle.
  - A lane with v >= NUM_CLASSES is not counted, sets the err latch, and still consumes a tree slot.
  - The beat counter increments per beat. The beat that completes NUM_TREES/TREES_PER_BEAT beats moves the block to SCAN.
- SCAN:
  - in_ready=0. Idx steps 0..NUM_CLASSES-1, one class per cycle.
  - Idx 0 loads best=count[0], best_idx=0, tie=0.
  - For each later idx: count>best replaces best and best_idx and clears tie; count==best sets tie.
  - The cycle after idx NUM_CLASSES-1 is compared, the block enters OUT.
- Output selection on entering OUT:
  - out_class = best_idx, or TIE_CLASS if TIE_MODE=1 and tie=1.
  - out_count = best, out_tie = tie, out_err = err latch.
- Latency: the last input beat is accepted at edge E; out_valid rises after edge E+NUM_CLASSES+1.
- OUT:
  - in_ready=0. out_valid=1; all outputs are held stable until out_ready.
  - On the handshake: counters, beat counter and err latch clear, out_valid drops, and the block returns to ACCUM. in_ready=1 from the next cycle.
  - No overlap with the next frame; in_votes is ignored whenever in_ready=0.
- All votes invalid: all counts are 0, so out_class=0 (or TIE_CLASS if TIE_MODE=1), out_count=0, out_tie=1, out_err=1.
- Counters cannot overflow: CNT_W holds NUM_TREES exactly.
- Equivalence: NUM_TREES=6, NUM_CLASSES=4, TIE_MODE=0 gives the same class as the previous combinational voter.

Decomposition:
- Package forest_vote_pkg holds:
  - the state enum (ACCUM, SCAN, OUT);
  - the clog2-derived widths CNT_W and BEAT_W;
  - TIE_MODE encodings;
  - elaboration-time parameter legality checks.
- Sub-module majority_vote_counter_bank:
  - holds NUM_CLASSES CNT_W-bit counters;
  - does per-beat multi-lane increments and the invalid-vote detect;
  - has a synchronous clear input.
- The FSM, argmax scan and output registers stay in the top module.

Test Plan:
1. Defaults; beats {0,1},{1,2},{1,3}, out_ready=1 -> out_class=1, out_count=3, tie=0, err=0; out_valid exactly 5 cycles after the last accept edge.
2. Beats {0,0},{2,2},{1,3} -> TIE_MODE=0: class 0, count 2, tie=1. Same stimulus with TIE_MODE=1, TIE_CLASS=3 -> class 3, count 2, tie=1.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid beats ignored. After the handshake, in_ready=1 next cycle and a second frame {2,2}x3 gives class 2, count 6.
4. NUM_CLASSES=3; beats {3,0},{0,1},{3,3} -> vote 3 not counted, class 0, count 2, tie=0, err=1. An all-3 frame -> class 0, count 0, tie=1, err=1.
5. Reset mid-frame: assert rst_n low after 2 beats -> outputs clear immediately. The next full frame {1,1}x3 gives class 1, count 6, unaffected by pre-reset votes.
6. Sweep TREES_PER_BEAT=1 and 3 (NUM_TREES=6) with random votes, back-to-back frames -> every result matches the reference model's argmax, lowest index winning ties.
